// File: rtl/star_box_writer.sv
// star_box_writer: fills a rectangular box of the 60x60, 3-bit image RAM with a
// constant colour, one pixel per clock, in raster order (address = y*60 + x).
// Used to blank a star once its bounding box is known.
// Build option: define STAR_BOX_OUTLINE_EN to write only the box perimeter;
// traversal order and cycle count stay the same, interior cycles hold wrEn low.
module star_box_writer #(
    parameter int unsigned xSz    = 6,
    parameter int unsigned ySz    = 6,
    parameter int unsigned addrSz = 12,
    parameter int unsigned colSz  = 3,
    parameter int unsigned X_RES  = 60,
    parameter int unsigned Y_RES  = 60
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [xSz-1:0]    xLeft,
    input  logic [xSz-1:0]    xRight,
    input  logic [ySz-1:0]    yTop,
    input  logic [ySz-1:0]    yBottom,
    input  logic [colSz-1:0]  colourIn,
    output logic [addrSz-1:0] wrAddress,
    output logic [colSz-1:0]  wrData,
    output logic              wrEn,
    output logic              busy,
    output logic              done,
    output logic              errBox
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } stateType;

    localparam logic [xSz-1:0] xMax = xSz'(X_RES - 1);
    localparam logic [ySz-1:0] yMax = ySz'(Y_RES - 1);

    stateType          state, stateNext;

    // Current pixel counters and latched box bounds
    logic [xSz-1:0]    xCnt, xCntNext;
    logic [ySz-1:0]    yCnt, yCntNext;
    logic [xSz-1:0]    xLeftQ, xLeftNext;
    logic [xSz-1:0]    xRightQ, xRightNext;
    logic [ySz-1:0]    yTopQ, yTopNext;
    logic [ySz-1:0]    yBottomQ, yBottomNext;

    // Next values of the registered outputs
    logic [addrSz-1:0] wrAddressNext;
    logic [colSz-1:0]  wrDataNext;
    logic              wrEnNext;
    logic              busyNext;
    logic              doneNext;
    logic              errBoxNext;

    // Step helpers used inside WRITE
    logic              lastCol;
    logic              lastRow;
    logic [xSz-1:0]    xStep;
    logic [ySz-1:0]    yStep;
    logic              reqValid;

    // Row-major address y*60 + x built from shifts: 60 = 32 + 16 + 8 + 4
    function automatic logic [addrSz-1:0] pixAddr(input logic [xSz-1:0] xv,
                                                  input logic [ySz-1:0] yv);
        logic [addrSz-1:0] yw;
        yw = addrSz'(yv);
        return (yw << 5) + (yw << 4) + (yw << 3) + (yw << 2) + addrSz'(xv);
    endfunction

    // A request is rejected for an inverted or out-of-image box
    assign reqValid = (xLeft <= xRight) && (yTop <= yBottom) &&
                      (xRight <= xMax) && (yBottom <= yMax);

    // State, counters, latched bounds and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            xCnt      <= '0;
            yCnt      <= '0;
            xLeftQ    <= '0;
            xRightQ   <= '0;
            yTopQ     <= '0;
            yBottomQ  <= '0;
            wrAddress <= '0;
            wrData    <= '0;
            wrEn      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            errBox    <= 1'b0;
        end else begin
            state     <= stateNext;
            xCnt      <= xCntNext;
            yCnt      <= yCntNext;
            xLeftQ    <= xLeftNext;
            xRightQ   <= xRightNext;
            yTopQ     <= yTopNext;
            yBottomQ  <= yBottomNext;
            wrAddress <= wrAddressNext;
            wrData    <= wrDataNext;
            wrEn      <= wrEnNext;
            busy      <= busyNext;
            done      <= doneNext;
            errBox    <= errBoxNext;
        end
    end

    // Next-state, raster stepping and next output values
    always_comb begin
        stateNext     = state;
        xCntNext      = xCnt;
        yCntNext      = yCnt;
        xLeftNext     = xLeftQ;
        xRightNext    = xRightQ;
        yTopNext      = yTopQ;
        yBottomNext   = yBottomQ;
        wrAddressNext = wrAddress;
        wrDataNext    = wrData;
        wrEnNext      = 1'b0;
        busyNext      = 1'b0;
        doneNext      = 1'b0;
        errBoxNext    = 1'b0;

        lastCol = (xCnt == xRightQ);
        lastRow = (yCnt == yBottomQ);
        xStep   = lastCol ? xLeftQ : xCnt + xSz'(1);
        yStep   = lastCol ? yCnt + ySz'(1) : yCnt;

        case (state)
            IDLE: begin
                if (start) begin
                    xLeftNext   = xLeft;
                    xRightNext  = xRight;
                    yTopNext    = yTop;
                    yBottomNext = yBottom;
                    wrDataNext  = colourIn;
                    if (reqValid) begin
                        // First pixel is the top-left corner, always on the perimeter
                        stateNext     = WRITE;
                        xCntNext      = xLeft;
                        yCntNext      = yTop;
                        wrAddressNext = pixAddr(xLeft, yTop);
                        wrEnNext      = 1'b1;
                        busyNext      = 1'b1;
                    end else begin
                        stateNext  = DONE;
                        doneNext   = 1'b1;
                        errBoxNext = 1'b1;
                    end
                end
            end

            WRITE: begin
                if (lastCol && lastRow) begin
                    stateNext = DONE;
                    doneNext  = 1'b1;
                end else begin
                    xCntNext      = xStep;
                    yCntNext      = yStep;
                    wrAddressNext = pixAddr(xStep, yStep);
                    busyNext      = 1'b1;
`ifdef STAR_BOX_OUTLINE_EN
                    wrEnNext      = (xStep == xLeftQ) || (xStep == xRightQ) ||
                                    (yStep == yTopQ)  || (yStep == yBottomQ);
`else
                    wrEnNext      = 1'b1;
`endif
                end
            end

            DONE: begin
                stateNext = IDLE;
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule
